// File: rtl/ccip_c1_tx_buffer.sv
// CCI-P Tx channel 1 write-request elastic buffer; issues queued requests only while registered almost-full is low.
// Optional stall/peak-occupancy statistics are built when CCIP_C1_TXBUF_STATS_EN is defined.
module ccip_c1_tx_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned HDR_W  = 80,
    parameter int unsigned DATA_W = 512
) (
    input  logic                   Clk_400,
    input  logic                   SoftReset,
    input  logic                   in_valid,
    input  logic [HDR_W-1:0]       in_hdr,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   in_ready,
    input  logic                   c1TxAlmFull,
    output logic                   c1_valid,
    output logic [HDR_W-1:0]       c1_hdr,
    output logic [DATA_W-1:0]      c1_data,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [31:0]            stall_cycles,
    output logic [$clog2(DEPTH):0] max_occupancy
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned ENT_W = HDR_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             almFullQ;
    logic             pushEn;
    logic             popEn;
    logic [CNT_W-1:0] occNext;

    // Transfer decisions use only registered state, so no input reaches an output combinationally.
    always_comb begin
        pushEn  = in_valid & in_ready;
        popEn   = (occupancy != '0) & ~almFullQ;
        occNext = occupancy;
        if (pushEn & ~popEn) begin
            occNext = occupancy + CNT_W'(1);
        end else if (~pushEn & popEn) begin
            occNext = occupancy - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk_400) begin
        if (pushEn & ~SoftReset) begin
            mem[wrPtr] <= {in_hdr, in_data};
        end
    end

    // in_ready looks at next occupancy so a full queue never sees a push, even with a same-cycle pop.
    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            occupancy <= '0;
            almFullQ  <= 1'b0;
            in_ready  <= 1'b0;
            c1_valid  <= 1'b0;
            c1_hdr    <= '0;
            c1_data   <= '0;
        end else begin
            almFullQ  <= c1TxAlmFull;
            occupancy <= occNext;
            in_ready  <= (occNext < CNT_W'(DEPTH));
            c1_valid  <= popEn;
            if (pushEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (popEn) begin
                rdPtr             <= rdPtr + PTR_W'(1);
                {c1_hdr, c1_data} <= mem[rdPtr];
            end
        end
    end

`ifdef CCIP_C1_TXBUF_STATS_EN
    // Stall counter saturates; peak tracks the occupancy value being registered this edge.
    always_ff @(posedge Clk_400) begin
        if (SoftReset) begin
            stall_cycles  <= '0;
            max_occupancy <= '0;
        end else begin
            if ((occupancy != '0) && almFullQ && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (occNext > max_occupancy) begin
                max_occupancy <= occNext;
            end
        end
    end
`else
    assign stall_cycles  = '0;
    assign max_occupancy = '0;
`endif

endmodule

// File: tb/tb_ccip_c1_tx_buffer.sv
// Self-checking bench for ccip_c1_tx_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_ccip_c1_tx_buffer;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned HDR_W  = 80;
    localparam int unsigned DATA_W = 512;
    localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W  = HDR_W + DATA_W;

    logic              Clk_400 = 1'b0;
    logic              SoftReset = 1'b1;
    logic              in_valid = 1'b0;
    logic [HDR_W-1:0]  in_hdr = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              c1TxAlmFull = 1'b0;
    logic              c1_valid;
    logic [HDR_W-1:0]  c1_hdr;
    logic [DATA_W-1:0] c1_data;
    logic [OCC_W-1:0]  occupancy;
    logic [31:0]       stall_cycles;
    logic [OCC_W-1:0]  max_occupancy;

    int nTests = 0;
    int nFail  = 0;

    ccip_c1_tx_buffer #(.DEPTH(DEPTH), .HDR_W(HDR_W), .DATA_W(DATA_W)) dut (
        .Clk_400(Clk_400), .SoftReset(SoftReset), .in_valid(in_valid), .in_hdr(in_hdr),
        .in_data(in_data), .in_ready(in_ready), .c1TxAlmFull(c1TxAlmFull), .c1_valid(c1_valid),
        .c1_hdr(c1_hdr), .c1_data(c1_data), .occupancy(occupancy), .stall_cycles(stall_cycles),
        .max_occupancy(max_occupancy)
    );

    always #5 Clk_400 = ~Clk_400;

    // Reference model: a FIFO of requests plus the one-cycle-late almost-full view.
    logic [ENT_W-1:0]  mq[$];
    logic              mAlmQ = 1'b0;
    logic              mReady = 1'b0;
    logic              mValid = 1'b0;
    logic [HDR_W-1:0]  mHdr = '0;
    logic [DATA_W-1:0] mData = '0;
    logic [31:0]       mStall = '0;
    int                mMax = 0;

    always @(posedge Clk_400) begin
        if (SoftReset) begin
            mq.delete();
            mAlmQ = 1'b0; mReady = 1'b0; mValid = 1'b0;
            mHdr = '0; mData = '0; mStall = '0; mMax = 0;
        end else begin
            bit doPush, doPop;
            doPush = in_valid && mReady;
            doPop  = (mq.size() != 0) && !mAlmQ;
            if ((mq.size() != 0) && mAlmQ && (mStall != 32'hFFFF_FFFF)) mStall = mStall + 32'd1;
            if (doPop) begin
                mValid = 1'b1;
                {mHdr, mData} = mq.pop_front();
            end else begin
                mValid = 1'b0;
            end
            if (doPush) mq.push_back({in_hdr, in_data});
            mAlmQ  = c1TxAlmFull;
            mReady = (mq.size() < DEPTH);
            if (mq.size() > mMax) mMax = mq.size();
        end
    end

    function automatic logic [DATA_W-1:0] rndData();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic logic [HDR_W-1:0] rndHdr();
        logic [95:0] h;
        h = {$urandom(), $urandom(), $urandom()};
        return h[HDR_W-1:0];
    endfunction

    task automatic step();
        @(posedge Clk_400);
        @(negedge Clk_400);
    endtask

    task automatic do_reset();
        SoftReset = 1'b1; in_valid = 1'b0; c1TxAlmFull = 1'b0;
        step();
        SoftReset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        SoftReset = 1'b1; in_valid = 1'b0; c1TxAlmFull = 1'b0;
        step();
        nTests++;
        if (c1_valid !== 1'b0 || occupancy !== '0 || in_ready !== 1'b0 || c1_hdr !== '0 || c1_data !== '0) begin
            nFail++;
            $display("FAIL reset_state: valid=%b occ=%0d ready=%b hdr=%h expected 0/0/0/0", c1_valid, occupancy, in_ready, c1_hdr);
        end
        SoftReset = 1'b0;
        step();
        nTests++;
        if (in_ready !== 1'b1) begin
            nFail++;
            $display("FAIL reset_ready_after: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_hdr = 80'h1; in_data = 512'hA5;
        step();
        in_valid = 1'b0;
        nTests++;
        if (c1_valid !== 1'b0 || occupancy !== OCC_W'(1)) begin
            nFail++;
            $display("FAIL single_early: valid=%b occ=%0d expected 0/1", c1_valid, occupancy);
        end
        step();
        nTests++;
        if (c1_valid !== 1'b1 || c1_hdr !== 80'h1 || c1_data !== 512'hA5) begin
            nFail++;
            $display("FAIL single_issue: valid=%b hdr=%h data=%h expected 1/1/a5", c1_valid, c1_hdr, c1_data);
        end
        step();
        nTests++;
        if (c1_valid !== 1'b0 || occupancy !== '0 || c1_hdr !== 80'h1) begin
            nFail++;
            $display("FAIL single_after: valid=%b occ=%0d hdr=%h expected 0/0/1 (held)", c1_valid, occupancy, c1_hdr);
        end
    endtask

    task automatic test_fill();
        logic [ENT_W-1:0] exp[$];
        int outs = 0, firstCyc = -1;
        bit acc;
        do_reset();
        c1TxAlmFull = 1'b1;
        step(); step();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_hdr = rndHdr(); in_data = rndData();
            exp.push_back({in_hdr, in_data});
            nTests++;
            if (in_ready !== 1'b1) begin
                nFail++;
                $display("FAIL fill_ready: push %0d in_ready=%b expected 1", i, in_ready);
            end
            step();
        end
        in_hdr = rndHdr(); in_data = rndData();
        exp.push_back({in_hdr, in_data});
        nTests++;
        if (in_ready !== 1'b0 || occupancy !== OCC_W'(16)) begin
            nFail++;
            $display("FAIL fill_full: ready=%b occ=%0d expected 0/16", in_ready, occupancy);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            nTests++;
            if (in_ready !== 1'b0 || occupancy !== OCC_W'(16) || c1_valid !== 1'b0) begin
                nFail++;
                $display("FAIL fill_hold: cyc %0d ready=%b occ=%0d valid=%b expected 0/16/0", i, in_ready, occupancy, c1_valid);
            end
        end
        c1TxAlmFull = 1'b0;
        for (int c = 0; c < 40; c++) begin
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
            if (c1_valid) begin
                nTests++;
                if (outs >= 17 || {c1_hdr, c1_data} !== exp[outs]) begin
                    nFail++;
                    $display("FAIL fill_order: output %0d hdr=%h wrong or extra", outs, c1_hdr);
                end
                if (outs == 0) firstCyc = c;
                else if (outs < 16) begin
                    nTests++;
                    if (c != firstCyc + outs) begin
                        nFail++;
                        $display("FAIL fill_bubble: output %0d at cyc %0d expected %0d", outs, c, firstCyc + outs);
                    end
                end
                outs++;
            end
        end
        nTests++;
        if (outs != 17) begin
            nFail++;
            $display("FAIL fill_count: %0d outputs expected 17", outs);
        end
    endtask

    task automatic test_stream();
        logic [ENT_W-1:0] exp[$];
        int outs = 0, first = -1, last = -1;
        do_reset();
        for (int c = 0; c < 105; c++) begin
            if (c < 100) begin
                in_valid = 1'b1; in_hdr = rndHdr(); in_data = rndData();
                exp.push_back({in_hdr, in_data});
                nTests++;
                if (in_ready !== 1'b1) begin
                    nFail++;
                    $display("FAIL stream_ready: cyc %0d in_ready=%b expected 1", c, in_ready);
                end
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c < 100) begin
                nTests++;
                if (occupancy !== OCC_W'(1)) begin
                    nFail++;
                    $display("FAIL stream_occ: cyc %0d occ=%0d expected 1", c, occupancy);
                end
            end
            if (c1_valid) begin
                nTests++;
                if (outs >= exp.size() || {c1_hdr, c1_data} !== exp[outs]) begin
                    nFail++;
                    $display("FAIL stream_order: output %0d hdr=%h wrong or extra", outs, c1_hdr);
                end
                if (first < 0) first = c;
                last = c;
                outs++;
            end
        end
        nTests++;
        if (outs != 100 || first != 1 || last - first != 99) begin
            nFail++;
            $display("FAIL stream_count: outs=%0d first=%0d last=%0d expected 100/1/100", outs, first, last);
        end
    endtask

    task automatic test_almfull_toggle();
        logic [ENT_W-1:0] exp[$];
        int outs = 0, early = 0, late = 0;
        bit acc;
        do_reset();
        for (int c = 0; c < 75; c++) begin
            if (c < 40 && !in_valid) begin
                in_valid = 1'b1; in_hdr = rndHdr(); in_data = rndData();
                exp.push_back({in_hdr, in_data});
            end
            c1TxAlmFull = (c >= 10 && c < 25);
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
            if (c1_valid) begin
                if (c >= 10 && c < 12) early++;
                if (c >= 12 && c < 25) late++;
                nTests++;
                if (outs >= exp.size() || {c1_hdr, c1_data} !== exp[outs]) begin
                    nFail++;
                    $display("FAIL almfull_order: output %0d hdr=%h wrong or extra", outs, c1_hdr);
                end
                outs++;
            end
        end
        nTests++;
        if (early > 2 || late != 0) begin
            nFail++;
            $display("FAIL almfull_gate: %0d pulses after rise, %0d while held, expected <=2 and 0", early, late);
        end
        nTests++;
        if (outs != exp.size()) begin
            nFail++;
            $display("FAIL almfull_drain: %0d outputs expected %0d", outs, exp.size());
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        c1TxAlmFull = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_hdr = rndHdr(); in_data = rndData();
            step();
        end
        in_valid = 1'b0;
        nTests++;
        if (occupancy !== OCC_W'(7)) begin
            nFail++;
            $display("FAIL midop_setup: occ=%0d expected 7", occupancy);
        end
        SoftReset = 1'b1; c1TxAlmFull = 1'b0;
        step();
        SoftReset = 1'b0;
        nTests++;
        if (c1_valid !== 1'b0 || occupancy !== '0) begin
            nFail++;
            $display("FAIL midop_reset: valid=%b occ=%0d expected 0/0", c1_valid, occupancy);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            nTests++;
            if (c1_valid !== 1'b0 || occupancy !== '0) begin
                nFail++;
                $display("FAIL midop_stale: cyc %0d valid=%b occ=%0d expected 0/0", i, c1_valid, occupancy);
            end
        end
    endtask

    task automatic test_stats();
        logic [31:0] s0;
        do_reset();
        c1TxAlmFull = 1'b1;
        step(); step();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_hdr = rndHdr(); in_data = rndData();
            step();
        end
        in_valid = 1'b0;
        s0 = stall_cycles;
        for (int i = 0; i < 10; i++) step();
`ifdef CCIP_C1_TXBUF_STATS_EN
        nTests++;
        if (stall_cycles - s0 !== 32'd10 || stall_cycles !== mStall) begin
            nFail++;
            $display("FAIL stats_stall: delta=%0d total=%0d expected 10/%0d", stall_cycles - s0, stall_cycles, mStall);
        end
        nTests++;
        if (max_occupancy !== OCC_W'(3)) begin
            nFail++;
            $display("FAIL stats_max: max_occupancy=%0d expected 3", max_occupancy);
        end
`else
        nTests++;
        if (stall_cycles !== 32'd0 || max_occupancy !== '0) begin
            nFail++;
            $display("FAIL stats_off: stall=%0d max=%0d expected 0/0", stall_cycles, max_occupancy);
        end
`endif
        c1TxAlmFull = 1'b0;
        for (int i = 0; i < 6; i++) step();
    endtask

    task automatic test_back_to_back();
        bit acc;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if (!in_valid && ($urandom_range(9) < 7)) begin
                in_valid = 1'b1; in_hdr = rndHdr(); in_data = rndData();
            end
            if ($urandom_range(7) == 0) c1TxAlmFull = ~c1TxAlmFull;
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
            nTests++;
            if (c1_valid !== mValid || c1_hdr !== mHdr || c1_data !== mData) begin
                nFail++;
                $display("FAIL rand_out: cyc %0d valid=%b hdr=%h expected %b/%h", c, c1_valid, c1_hdr, mValid, mHdr);
            end
            nTests++;
            if (in_ready !== mReady || occupancy !== OCC_W'(mq.size())) begin
                nFail++;
                $display("FAIL rand_state: cyc %0d ready=%b occ=%0d expected %b/%0d", c, in_ready, occupancy, mReady, mq.size());
            end
            nTests++;
`ifdef CCIP_C1_TXBUF_STATS_EN
            if (stall_cycles !== mStall || max_occupancy !== OCC_W'(mMax)) begin
                nFail++;
                $display("FAIL rand_stats: cyc %0d stall=%0d max=%0d expected %0d/%0d", c, stall_cycles, max_occupancy, mStall, mMax);
            end
`else
            if (stall_cycles !== 32'd0 || max_occupancy !== '0) begin
                nFail++;
                $display("FAIL rand_stats: cyc %0d stall=%0d max=%0d expected 0/0", c, stall_cycles, max_occupancy);
            end
`endif
        end
    endtask

    initial begin
        #200000;
        nFail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_almfull_toggle();
        test_reset_midop();
        test_stats();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
